// File: rtl/capture_buf_ctrl.sv
// Capture sequencer: records capture_len samples into a local RAM, then drains them over a valid/ready stream.
// Optional build macro CAPTURE_DECIM_EN adds a decim[7:0] input that keeps every (decim+1)-th valid sample.
module capture_buf_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
`ifdef CAPTURE_DECIM_EN
  input  logic [7:0]            decim,
`endif
  input  logic [CNT_WIDTH-1:0]  capture_len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_data_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  capture_done,
  output logic                  drain_done,
  output logic [CNT_WIDTH-1:0]  fill_level,
  output logic                  event_bad_len,
  output logic                  event_arm_when_busy,
  output logic                  event_data_dropped
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  state_t                state;
  logic [CNT_WIDTH-1:0]  len, wr_cnt, rd_cnt, rd_iss;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q, skid_data;
  logic                  ram_q_vld, skid_vld;
  logic                  len_ok, arm_ok, keep, wr_en, last_wr, pop, last_rd, rd_issue;
  logic [1:0]            occ;

`ifdef CAPTURE_DECIM_EN
  logic [7:0] decim_q, decim_cnt;
  assign keep = (decim_cnt == 8'd0);
`else
  assign keep = 1'b1;
`endif

  assign len_ok  = (capture_len != '0) && (capture_len <= DEPTH_C);
  assign arm_ok  = arm && !abort && (state == IDLE) && len_ok;
  assign wr_en   = (state == CAPTURE) && !abort && in_data_vld && keep;
  assign last_wr = wr_en && (wr_cnt == len - ONE);
  assign pop     = out_vld && out_rdy;
  assign last_rd = (state == DRAIN) && !abort && pop && (rd_cnt == len - ONE);

  // Output reg + skid + one read in flight: issue only if the data can land even if the stream stalls.
  assign occ      = 2'(out_vld) + 2'(skid_vld) + 2'(ram_q_vld);
  assign rd_issue = (state == DRAIN) && !abort && (rd_iss != len) && ((occ - 2'(pop)) <= 2'd1);

  assign busy         = (state != IDLE);
  assign capture_done = last_wr;
  assign drain_done   = last_rd;
  assign fill_level   = wr_cnt - rd_cnt;

  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_cnt[ADDR_WIDTH-1:0]] <= in_data;
    if (rd_issue) ram_q <= mem[rd_iss[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      len                 <= '0;
      wr_cnt              <= '0;
      rd_cnt              <= '0;
      rd_iss              <= '0;
      out_data            <= '0;
      out_vld             <= 1'b0;
      skid_data           <= '0;
      skid_vld            <= 1'b0;
      ram_q_vld           <= 1'b0;
      event_bad_len       <= 1'b0;
      event_arm_when_busy <= 1'b0;
      event_data_dropped  <= 1'b0;
`ifdef CAPTURE_DECIM_EN
      decim_q             <= 8'd0;
      decim_cnt           <= 8'd0;
`endif
    end else begin
      // Event pulses appear the cycle after the input that caused them.
      event_bad_len       <= arm && !abort && (state == IDLE) && !len_ok;
      event_arm_when_busy <= arm && !abort && (state != IDLE);
      event_data_dropped  <= in_data_vld && (state != CAPTURE);
      ram_q_vld           <= rd_issue;

      if (abort) begin
        state     <= IDLE;
        wr_cnt    <= '0;
        rd_cnt    <= '0;
        rd_iss    <= '0;
        out_vld   <= 1'b0;
        skid_vld  <= 1'b0;
        ram_q_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm_ok) begin
              state  <= CAPTURE;
              len    <= capture_len;
              wr_cnt <= '0;
              rd_cnt <= '0;
              rd_iss <= '0;
`ifdef CAPTURE_DECIM_EN
              decim_q   <= decim;
              decim_cnt <= 8'd0;
`endif
            end
          end
          CAPTURE: begin
`ifdef CAPTURE_DECIM_EN
            if (in_data_vld) decim_cnt <= (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
`endif
            if (wr_en) begin
              wr_cnt <= wr_cnt + ONE;
              if (last_wr) state <= DRAIN;
            end
          end
          DRAIN: begin
            if (rd_issue) rd_iss <= rd_iss + ONE;
            if (pop)      rd_cnt <= rd_cnt + ONE;
            if (pop || !out_vld) begin
              if (skid_vld) begin
                out_data  <= skid_data;
                out_vld   <= 1'b1;
                skid_data <= ram_q;
                skid_vld  <= ram_q_vld;
              end else begin
                out_vld <= ram_q_vld;
                if (ram_q_vld) out_data <= ram_q;
              end
            end else if (ram_q_vld) begin
              skid_data <= ram_q;
              skid_vld  <= 1'b1;
            end
            if (last_rd) begin
              state    <= IDLE;
              out_vld  <= 1'b0;
              skid_vld <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
